// File: rtl/sipo_deser_param.sv
// Serial-in/parallel-out deserialiser: shifts din into q, captures each full word into word/word_valid.
// word_valid rises on the edge that takes the last bit; serial input never stalls, drops set overrun; SIPO_PARITY_EN adds a parity bit and par_err.
module sipo_deser_param #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
`ifdef SIPO_PARITY_EN
  localparam int FRAME    = WIDTH + 1,
`else
  localparam int FRAME    = WIDTH,
`endif
  localparam int CW       = $clog2(FRAME + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [CW-1:0]    bit_cnt,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  input  logic             word_ready,
`ifdef SIPO_PARITY_EN
  output logic             par_err,
`endif
  output logic             overrun
);

  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             shift_en;
  logic             done;
  logic             free;

  always_comb begin
    shift_en = din_valid;
`ifdef SIPO_PARITY_EN
    // the trailing parity bit is counted but never enters the shift register
    if (bit_cnt == LAST) shift_en = 1'b0;
`endif
    q_nxt = q;
    if (shift_en) q_nxt = MSB_FIRST ? {q[WIDTH-2:0], din} : {din, q[WIDTH-1:1]};
    done    = din_valid && (bit_cnt == LAST);
    cnt_nxt = bit_cnt;
    if (din_valid) cnt_nxt = done ? '0 : bit_cnt + 1'b1;
    free = !word_valid || word_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q          <= '0;
      q_bar      <= '1;
      bit_cnt    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
`ifdef SIPO_PARITY_EN
      par_err    <= 1'b0;
`endif
    end else if (clear) begin
      q          <= '0;
      q_bar      <= '1;
      bit_cnt    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
`ifdef SIPO_PARITY_EN
      par_err    <= 1'b0;
`endif
    end else begin
      q       <= q_nxt;
      q_bar   <= ~q_nxt;
      bit_cnt <= cnt_nxt;
      if (done) begin
        if (free) begin
          word       <= q_nxt;
          word_valid <= 1'b1;
`ifdef SIPO_PARITY_EN
          par_err    <= (^q_nxt) ^ din;
`endif
        end else begin
          overrun <= 1'b1;
        end
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deser_param.sv
// Random and directed stimulus for sipo_deser_param (MSB-first and LSB-first instances) against a bit-history model.
module tb_sipo_deser_param;
  localparam int W  = 8;
`ifdef SIPO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif
  localparam int CW = $clog2(FL + 1);

  logic clk, rst_n, clear, din, din_valid, word_ready;
  logic [W-1:0]  q_m, qb_m, word_m, q_l, qb_l, word_l;
  logic [CW-1:0] cnt_m, cnt_l;
  logic          wv_m, ov_m, wv_l, ov_l;
`ifdef SIPO_PARITY_EN
  logic          pe_m, pe_l;
`endif

  sipo_deser_param #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .clear(clear), .din(din), .din_valid(din_valid),
    .q(q_m), .q_bar(qb_m), .bit_cnt(cnt_m), .word(word_m), .word_valid(wv_m),
    .word_ready(word_ready),
`ifdef SIPO_PARITY_EN
    .par_err(pe_m),
`endif
    .overrun(ov_m));

  sipo_deser_param #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .clear(clear), .din(din), .din_valid(din_valid),
    .q(q_l), .q_bar(qb_l), .bit_cnt(cnt_l), .word(word_l), .word_valid(wv_l),
    .word_ready(word_ready),
`ifdef SIPO_PARITY_EN
    .par_err(pe_l),
`endif
    .overrun(ov_l));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: data bits shifted since reset/clear, position within frame, holding register state.
  bit           hist[$];
  int           pos;
  bit           fpar;
  logic [W-1:0] mw_m, mw_l;
  bit           mwv, mov, mpe;

  function automatic logic [W-1:0] q_of(input bit msb);
    logic [W-1:0] r;
    int n;
    r = '0;
    n = hist.size();
    for (int i = 0; i < n; i++) begin
      if (msb) r[n-1-i] = hist[i];
      else     r[W-n+i] = hist[i];
    end
    return r;
  endfunction

  task automatic model_reset();
    hist.delete();
    pos = 0; fpar = 0; mw_m = '0; mw_l = '0; mwv = 0; mov = 0; mpe = 0;
  endtask

  task automatic model_step(input bit c, input bit d, input bit v, input bit r);
    bit done;
    done = 0;
    if (c) begin
      model_reset();
    end else begin
      if (v) begin
        if (pos < W) begin
          hist.push_back(d);
          if (hist.size() > W) void'(hist.pop_front());
          fpar ^= d;
        end
        pos++;
        if (pos == FL) begin done = 1; pos = 0; end
      end
      if (done) begin
        if (!mwv || r) begin
          mw_m = q_of(1'b1); mw_l = q_of(1'b0); mwv = 1; mpe = fpar ^ d;
        end else begin
          mov = 1;
        end
        fpar = 0;
      end else if (mwv && r) begin
        mwv = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [W-1:0] em, el, nm, nl;
    em = q_of(1'b1); el = q_of(1'b0);
    nm = ~em;        nl = ~el;
    chk("q_msb", q_m, em);       chk("q_lsb", q_l, el);
    chk("qbar_msb", qb_m, nm);   chk("qbar_lsb", qb_l, nl);
    chk("cnt_msb", cnt_m, pos);  chk("cnt_lsb", cnt_l, pos);
    chk("word_msb", word_m, mw_m); chk("word_lsb", word_l, mw_l);
    chk("wv_msb", wv_m, mwv);    chk("wv_lsb", wv_l, mwv);
    chk("ovr_msb", ov_m, mov);   chk("ovr_lsb", ov_l, mov);
`ifdef SIPO_PARITY_EN
    chk("perr_msb", pe_m, mpe);  chk("perr_lsb", pe_l, mpe);
`endif
  endtask

  // Called at a falling edge; returns at the next falling edge with outputs checked.
  task automatic cyc(input bit c, input bit d, input bit v, input bit r);
    clear = c; din = d; din_valid = v; word_ready = r;
    @(posedge clk);
    model_step(c, d, v, r);
    @(negedge clk);
    compare_all();
  endtask

  task automatic async_rst();
    clear = 0; din = 0; din_valid = 0; word_ready = 0;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("arst_q", q_m, 0);
    chk("arst_cnt", cnt_m, 0);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Data bits go out word[W-1] first; ready is asserted only on the frame's final bit.
  task automatic send_frame(input logic [W-1:0] w, input bit pb, input bit r, input bit gap);
    for (int i = W - 1; i >= 0; i--) begin
      cyc(1'b0, w[i], 1'b1, (i == 0 && FL == W) ? r : 1'b0);
      if (gap) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
    if (FL > W) cyc(1'b0, pb, 1'b1, r);
  endtask

  initial begin
    rst_n = 1'b0; clear = 0; din = 0; din_valid = 0; word_ready = 0;
    model_reset();
    @(negedge clk);
    compare_all();
    chk("rst_qbar", qb_m, 8'hFF);
    chk("rst_wv", wv_m, 0);
    rst_n = 1'b1;

    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    chk("t1_word", word_m, 8'hA5);
    chk("t1_word_lsb", word_l, 8'hA5);
    chk("t1_wv", wv_m, 1);
    chk("t1_cnt", cnt_m, 0);
    chk("t1_q", q_m, 8'hA5);
    chk("t1_qbar", qb_m, 8'h5A);

    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(8'hC0, 1'b0, 1'b0, 1'b0);
    chk("t2_word_msb", word_m, 8'hC0);
    chk("t2_word_lsb", word_l, 8'h03);

    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
    chk("t3_word", word_m, 8'h3C);
    chk("t3_ovr", ov_m, 1);
    chk("t3_wv", wv_m, 1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t3_clr_word", word_m, 0);
    chk("t3_clr_ovr", ov_m, 0);
    chk("t3_clr_wv", wv_m, 0);
    chk("t3_clr_qbar", qb_m, 8'hFF);
    chk("t3_clr_cnt", cnt_m, 0);

    send_frame(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    chk("t4_word", word_m, 8'h22);
    chk("t4_wv", wv_m, 1);
    chk("t4_ovr", ov_m, 0);

    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
    async_rst();
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    chk("t5_word", word_m, 8'h81);
    chk("t5_wv", wv_m, 1);

`ifdef SIPO_PARITY_EN
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    chk("p1_perr", pe_m, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    chk("p2_perr", pe_m, 1);
    chk("p2_word", word_m, 8'hA5);
`endif

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0)
        async_rst();
      else
        cyc($urandom_range(0, 149) == 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
